ex_stage: RTL and testbench

Single-issue execute stage sitting directly downstream of the instruction-fetch stage. It accepts one 32-bit RV64I-subset instruction at a time and executes it against an internal 32×64-bit register file. Loads and stores go through a valid/ack data-memory handshake. When it is done with an instruction, it returns a one-cycle finish pulse plus the next PC, which tells fetch to issue the following address.

---
 rtl/ex_stage_if.sv | 28 ++
 rtl/ex_stage.sv | 186 ++++++++++++++++++
 tb/tb_ex_stage.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_stage_if.sv
// Instruction-issue and data-memory signal bundle for the execute stage.
// The slave side is the execute stage; the master side is fetch plus data memory.
interface ex_stage_if;
   logic        i_inst_valid;
   logic [31:0] i_inst;
   logic [63:0] i_inst_addr;
   logic        o_inst_finish;
   logic [63:0] o_next_pc;
   logic        o_halt;
   logic        o_d_valid_addr;
   logic        o_d_we;
   logic [63:0] o_d_addr;
   logic [63:0] o_d_wdata;
   logic        i_d_valid_data;
   logic [63:0] i_d_data;

   modport slave (
      input  i_inst_valid, i_inst, i_inst_addr, i_d_valid_data, i_d_data,
      output o_inst_finish, o_next_pc, o_halt,
             o_d_valid_addr, o_d_we, o_d_addr, o_d_wdata
   );

   modport master (
      output i_inst_valid, i_inst, i_inst_addr, i_d_valid_data, i_d_data,
      input  o_inst_finish, o_next_pc, o_halt,
             o_d_valid_addr, o_d_we, o_d_addr, o_d_wdata
   );
endinterface

// File: rtl/ex_stage.sv
// Single-issue RV64I-subset execute stage with a 32x64 register file and a
// valid/ack data-memory port.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for i_inst_valid; captures instruction and address
// EXEC     | decode, ALU writeback, branch resolve, memory address compute
// MEM_REQ  | one-cycle o_d_valid_addr pulse
// MEM_WAIT | hold request fields until i_d_valid_data; load writeback
// DONE     | one-cycle o_inst_finish with o_next_pc
// HALT     | end-of-program word seen; sticky until reset
module ex_stage (
   input  logic      i_clk,
   input  logic      i_rst_n,
   ex_stage_if.slave bus
);
   typedef enum logic [2:0] {
      S_IDLE, S_EXEC, S_MEM_REQ, S_MEM_WAIT, S_DONE, S_HALT
   } state_t;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   state_t      state_q, state_d;
   logic [31:0] inst_q, inst_d;
   logic [63:0] pc_q, pc_d;
   logic [63:0] next_pc_q, next_pc_d;
   logic        d_we_q, d_we_d;
   logic [63:0] d_addr_q, d_addr_d;
   logic [63:0] d_wdata_q, d_wdata_d;
   logic [63:0] rf_q [32];

   logic        rf_we;
   logic [63:0] rf_wdata;
   logic        alu_ok;
   logic [63:0] alu_res;

   logic [6:0]  opcode;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [4:0]  rd, rs1, rs2;
   logic [63:0] rs1_v, rs2_v, imm_i, imm_s, imm_b;

   assign opcode = inst_q[6:0];
   assign rd     = inst_q[11:7];
   assign f3     = inst_q[14:12];
   assign rs1    = inst_q[19:15];
   assign rs2    = inst_q[24:20];
   assign f7     = inst_q[31:25];
   assign rs1_v  = rf_q[rs1];
   assign rs2_v  = rf_q[rs2];
   assign imm_i  = {{52{inst_q[31]}}, inst_q[31:20]};
   assign imm_s  = {{52{inst_q[31]}}, inst_q[31:25], inst_q[11:7]};
   assign imm_b  = {{51{inst_q[31]}}, inst_q[31], inst_q[7], inst_q[30:25],
                    inst_q[11:8], 1'b0};

   // ALU for register-register and register-immediate forms
   always_comb begin
      alu_ok  = 1'b0;
      alu_res = '0;
      if (opcode == OPC_OP) begin
         case (f3)
            3'b000: begin
               if (f7 == 7'b0000000) begin
                  alu_ok  = 1'b1;
                  alu_res = rs1_v + rs2_v;
               end else if (f7 == 7'b0100000) begin
                  alu_ok  = 1'b1;
                  alu_res = rs1_v - rs2_v;
               end
            end
            3'b100: begin alu_ok = 1'b1; alu_res = rs1_v ^ rs2_v; end
            3'b110: begin alu_ok = 1'b1; alu_res = rs1_v | rs2_v; end
            3'b111: begin alu_ok = 1'b1; alu_res = rs1_v & rs2_v; end
            default: ;
         endcase
      end else if (opcode == OPC_OP_IMM) begin
         case (f3)
            3'b000: begin alu_ok = 1'b1; alu_res = rs1_v + imm_i; end
            3'b100: begin alu_ok = 1'b1; alu_res = rs1_v ^ imm_i; end
            3'b110: begin alu_ok = 1'b1; alu_res = rs1_v | imm_i; end
            3'b111: begin alu_ok = 1'b1; alu_res = rs1_v & imm_i; end
            default: ;
         endcase
      end
   end

   // next-state, capture, memory request and register writeback control
   always_comb begin
      state_d   = state_q;
      inst_d    = inst_q;
      pc_d      = pc_q;
      next_pc_d = next_pc_q;
      d_we_d    = d_we_q;
      d_addr_d  = d_addr_q;
      d_wdata_d = d_wdata_q;
      rf_we     = 1'b0;
      rf_wdata  = alu_res;
      case (state_q)
         S_IDLE: begin
            if (bus.i_inst_valid) begin
               inst_d  = bus.i_inst;
               pc_d    = bus.i_inst_addr;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            next_pc_d = pc_q + 64'd4;
            state_d   = S_DONE;
            if (inst_q == 32'hFFFF_FFFF) begin
               state_d = S_HALT;
            end else if (alu_ok) begin
               rf_we = 1'b1;
            end else if (opcode == OPC_LOAD && f3 == 3'b011) begin
               d_addr_d = rs1_v + imm_i;
               d_we_d   = 1'b0;
               state_d  = S_MEM_REQ;
            end else if (opcode == OPC_STORE && f3 == 3'b011) begin
               d_addr_d  = rs1_v + imm_s;
               d_wdata_d = rs2_v;
               d_we_d    = 1'b1;
               state_d   = S_MEM_REQ;
            end else if (opcode == OPC_BRANCH) begin
               if ((f3 == 3'b000 && rs1_v == rs2_v) ||
                   (f3 == 3'b001 && rs1_v != rs2_v)) begin
                  next_pc_d = pc_q + imm_b;
               end
            end
         end
         S_MEM_REQ: state_d = S_MEM_WAIT;
         S_MEM_WAIT: begin
            if (bus.i_d_valid_data) begin
               if (!d_we_q) begin
                  rf_we    = 1'b1;
                  rf_wdata = bus.i_d_data;
               end
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         S_HALT:  state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase
   end

   // state and datapath registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= S_IDLE;
         inst_q    <= '0;
         pc_q      <= '0;
         next_pc_q <= '0;
         d_we_q    <= 1'b0;
         d_addr_q  <= '0;
         d_wdata_q <= '0;
      end else begin
         state_q   <= state_d;
         inst_q    <= inst_d;
         pc_q      <= pc_d;
         next_pc_q <= next_pc_d;
         d_we_q    <= d_we_d;
         d_addr_q  <= d_addr_d;
         d_wdata_q <= d_wdata_d;
      end
   end

   // register file; x0 is never written so it always reads zero
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < 32; i++) rf_q[i] <= '0;
      end else if (rf_we && rd != 5'd0) begin
         rf_q[rd] <= rf_wdata;
      end
   end

   assign bus.o_inst_finish  = (state_q == S_DONE);
   assign bus.o_halt         = (state_q == S_HALT);
   assign bus.o_d_valid_addr = (state_q == S_MEM_REQ);
   assign bus.o_next_pc      = next_pc_q;
   assign bus.o_d_we         = d_we_q;
   assign bus.o_d_addr       = d_addr_q;
   assign bus.o_d_wdata      = d_wdata_q;
endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: stimulus pushes expected finish / memory
// request events, a negedge monitor pops and compares them.
module tb_ex_stage;
   typedef struct {
      logic [63:0] pc;
      int          cyc;
   } fin_t;

   typedef struct {
      logic        we;
      logic [63:0] addr;
      logic [63:0] wdata;
      int          cyc;
   } mreq_t;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   halt_cyc = 1000000;
   int   mem_delay = 1;

   fin_t  fq[$];
   mreq_t mq[$];
   fin_t  mf;
   mreq_t mm;

   logic        pend = 1'b0;
   int          pend_cnt = 0;
   logic        pend_we = 1'b0;
   logic [63:0] pend_addr = '0;
   logic [63:0] mem [logic [63:0]];

   ex_stage_if bus();

   ex_stage dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   // monitor: reset values, sticky halt, finish and memory request events
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_finish",  64'(bus.o_inst_finish), 64'h0);
         chk("rst_next_pc", bus.o_next_pc, 64'h0);
         chk("rst_halt",    64'(bus.o_halt), 64'h0);
         chk("rst_dvalid",  64'(bus.o_d_valid_addr), 64'h0);
         chk("rst_dwe",     64'(bus.o_d_we), 64'h0);
         chk("rst_daddr",   bus.o_d_addr, 64'h0);
         chk("rst_dwdata",  bus.o_d_wdata, 64'h0);
         fq.delete();
         mq.delete();
      end else begin
         chk("halt", 64'(bus.o_halt), 64'(cyc >= halt_cyc));
         if (bus.o_inst_finish) begin
            if (fq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_finish: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
               mf = fq.pop_front();
               chk("next_pc", bus.o_next_pc, mf.pc);
               chk("finish_cycle", 64'(cyc), 64'(mf.cyc));
            end
         end
         if (bus.o_d_valid_addr) begin
            if (mq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_dreq: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
               mm = mq.pop_front();
               chk("d_we", 64'(bus.o_d_we), 64'(mm.we));
               chk("d_addr", bus.o_d_addr, mm.addr);
               if (mm.we) chk("d_wdata", bus.o_d_wdata, mm.wdata);
               chk("dreq_cycle", 64'(cyc), 64'(mm.cyc));
            end
         end
      end
   end

   // data memory: acks mem_delay cycles after the request cycle
   always @(negedge clk) begin
      bus.i_d_valid_data = 1'b0;
      if (pend) begin
         pend_cnt--;
         if (pend_cnt == 0) begin
            bus.i_d_valid_data = 1'b1;
            bus.i_d_data = (!pend_we && mem.exists(pend_addr)) ? mem[pend_addr] : 64'h0;
            pend = 1'b0;
         end
      end
      if (rst_n && bus.o_d_valid_addr) begin
         pend      = 1'b1;
         pend_cnt  = mem_delay;
         pend_we   = bus.o_d_we;
         pend_addr = bus.o_d_addr;
         if (bus.o_d_we) mem[bus.o_d_addr] = bus.o_d_wdata;
      end
   end

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1);
      return {imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'b0100011};
   endfunction

   function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
   endfunction

   task automatic send(input logic [31:0] inst, input logic [63:0] pc, output int n);
      @(posedge clk);
      #1;
      n = cyc;
      bus.i_inst_valid = 1'b1;
      bus.i_inst       = inst;
      bus.i_inst_addr  = pc;
      @(posedge clk);
      #1;
      bus.i_inst_valid = 1'b0;
      bus.i_inst       = '0;
   endtask

   task automatic wait_done();
      int b = 0;
      while (fq.size() != 0 || mq.size() != 0) begin
         if (b >= 100) begin
            $display("FAIL wait_done: expected events still pending after %0d cycles", b);
            $fatal(1, "bench stopped on timeout");
         end
         @(posedge clk);
         b++;
      end
   endtask

   task automatic alu(input logic [31:0] inst, input logic [63:0] pc, input logic [63:0] npc);
      int n;
      send(inst, pc, n);
      fq.push_back('{npc, n + 2});
      wait_done();
   endtask

   task automatic run_mem(input logic [31:0] inst, input logic [63:0] pc, input logic we,
                          input logic [63:0] addr, input logic [63:0] wdata);
      int n;
      send(inst, pc, n);
      mq.push_back('{we, addr, wdata, n + 2});
      fq.push_back('{pc + 64'd4, n + 3 + mem_delay});
      wait_done();
   endtask

   task automatic sd(input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] off,
                     input logic [63:0] pc, input logic [63:0] addr, input logic [63:0] wdata);
      run_mem(enc_s(off, rs2, rs1), pc, 1'b1, addr, wdata);
   endtask

   localparam logic [6:0] OPI = 7'b0010011;

   initial begin
      int n;
      rst_n            = 1'b0;
      bus.i_inst_valid = 1'bx;
      bus.i_inst       = 'x;
      bus.i_inst_addr  = 'x;
      repeat (3) @(posedge clk);
      #1;
      bus.i_inst_valid = 1'b0;
      bus.i_inst       = '0;
      bus.i_inst_addr  = '0;
      rst_n            = 1'b1;

      // every register reads zero after reset
      for (int i = 1; i < 32; i++) sd(5'(i), 5'd0, 12'd0, 64'h200 + 64'(4 * i), 64'h0, 64'h0);

      alu(enc_i(12'd5, 5'd0, 3'b000, 5'd1, OPI), 64'h0, 64'h4);
      alu(enc_r(7'b0000000, 5'd1, 5'd1, 3'b000, 5'd2), 64'h4, 64'h8);

      mem_delay = 3;
      sd(5'd2, 5'd0, 12'd8, 64'h8, 64'h8, 64'd10);
      run_mem(enc_i(12'd8, 5'd0, 3'b011, 5'd3, 7'b0000011), 64'hC, 1'b0, 64'h8, 64'h0);
      sd(5'd3, 5'd0, 12'd16, 64'h10, 64'd16, 64'd10);

      alu(enc_b(13'h1FF8, 5'd0, 5'd0, 3'b000), 64'h10, 64'h8);
      alu(enc_b(13'd16, 5'd0, 5'd0, 3'b001), 64'h10, 64'h14);
      alu(enc_b(13'd8, 5'd0, 5'd1, 3'b000), 64'hFFFF_FFFF_FFFF_FFFC, 64'h0);
      alu(enc_b(13'd8, 5'd0, 5'd0, 3'b000), 64'hFFFF_FFFF_FFFF_FFFC, 64'h4);
      alu(enc_b(13'h1FFC, 5'd2, 5'd1, 3'b001), 64'h20, 64'h1C);

      mem_delay = 1;
      alu(enc_i(12'd7, 5'd0, 3'b000, 5'd0, OPI), 64'h30, 64'h34);
      sd(5'd0, 5'd0, 12'd24, 64'h34, 64'd24, 64'h0);

      alu(enc_i(12'd1, 5'd0, 3'b000, 5'd5, OPI), 64'h38, 64'h3C);
      alu(enc_r(7'b0100000, 5'd5, 5'd0, 3'b000, 5'd4), 64'h3C, 64'h40);
      sd(5'd4, 5'd0, 12'd32, 64'h40, 64'd32, 64'hFFFF_FFFF_FFFF_FFFF);

      alu(enc_i(12'hFFF, 5'd0, 3'b000, 5'd6, OPI), 64'h44, 64'h48);
      alu(enc_i(12'h0F0, 5'd6, 3'b100, 5'd7, OPI), 64'h48, 64'h4C);
      alu(enc_i(12'h7FF, 5'd7, 3'b111, 5'd8, OPI), 64'h4C, 64'h50);
      alu(enc_r(7'b0000000, 5'd2, 5'd7, 3'b111, 5'd9), 64'h50, 64'h54);
      alu(enc_r(7'b0000000, 5'd2, 5'd8, 3'b100, 5'd10), 64'h54, 64'h58);
      alu(enc_r(7'b0000000, 5'd2, 5'd1, 3'b110, 5'd11), 64'h58, 64'h5C);
      alu(enc_i(12'h123, 5'd0, 3'b110, 5'd12, OPI), 64'h5C, 64'h60);
      alu(enc_r(7'b0000000, 5'd5, 5'd6, 3'b000, 5'd13), 64'h60, 64'h64);
      sd(5'd7, 5'd0, 12'd40, 64'h64, 64'd40, 64'hFFFF_FFFF_FFFF_FF0F);
      sd(5'd8, 5'd0, 12'd48, 64'h68, 64'd48, 64'h70F);
      sd(5'd9, 5'd0, 12'd56, 64'h6C, 64'd56, 64'hA);
      sd(5'd10, 5'd0, 12'd64, 64'h70, 64'd64, 64'h705);
      sd(5'd11, 5'd0, 12'd72, 64'h74, 64'd72, 64'hF);
      sd(5'd12, 5'd0, 12'd80, 64'h78, 64'd80, 64'h123);
      sd(5'd13, 5'd0, 12'd88, 64'h7C, 64'd88, 64'h0);
      sd(5'd2, 5'd12, 12'hFF8, 64'h80, 64'h11B, 64'd10);

      // unsupported encodings retire as NOPs and leave x1 alone
      alu({20'h12345, 5'd1, 7'b0110111}, 64'h84, 64'h88);
      alu(enc_r(7'b0000001, 5'd1, 5'd1, 3'b000, 5'd1), 64'h88, 64'h8C);
      sd(5'd1, 5'd0, 12'd96, 64'h8C, 64'd96, 64'd5);

      // reset while waiting on a load; the late ack must be dropped
      mem_delay = 6;
      send(enc_i(12'd8, 5'd0, 3'b011, 5'd3, 7'b0000011), 64'h90, n);
      mq.push_back('{1'b0, 64'h8, 64'h0, n + 2});
      fq.push_back('{64'h94, n + 9});
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (8) @(posedge clk);
      mem_delay = 2;
      sd(5'd3, 5'd0, 12'd0, 64'hA0, 64'h0, 64'h0);

      // halt word, then an ignored instruction
      send(32'hFFFF_FFFF, 64'hB0, n);
      halt_cyc = n + 2;
      repeat (3) @(posedge clk);
      send(enc_i(12'd1, 5'd0, 3'b000, 5'd1, OPI), 64'hB4, n);
      repeat (6) @(posedge clk);
      #1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
